// File: rtl/tdm_pkg.sv
// Shared types and constants for the 4-channel TDM merger.
// The channel index doubles as the routing tag on the merged stream.
package tdm_pkg;

  localparam int CH_IDX_W = 2;
  localparam int NCH      = 4;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational round-robin arbiter over four requesters.
// Search starts at ptr and wraps; en gates the one-hot grant only.
module rr_arbiter4
  import tdm_pkg::*;
(
  input  logic [NCH-1:0]      req,
  input  logic [CH_IDX_W-1:0] ptr,
  input  logic                en,
  output logic [NCH-1:0]      gnt,
  output logic [CH_IDX_W-1:0] gnt_idx
);

  logic                w_hit;
  logic [CH_IDX_W-1:0] w_idx;

  always_comb begin
    w_hit   = 1'b0;
    w_idx   = ptr;
    gnt_idx = ptr;
    for (int k = 0; k < NCH; k++) begin
      w_idx = ptr + CH_IDX_W'(k);
      if (!w_hit && req[w_idx]) begin
        w_hit   = 1'b1;
        gnt_idx = w_idx;
      end
    end
  end

  assign gnt = (en && w_hit) ? (NCH'(1) << gnt_idx) : '0;

endmodule

// File: rtl/tdm_mux_4to1.sv
// Merges four valid/ready channels into one registered stream,
// tagging each word with its source channel index.
module tdm_mux_4to1
  import tdm_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int NCH   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          in_valid,
  input  logic [WIDTH-1:0]    in_data0,
  input  logic [WIDTH-1:0]    in_data1,
  input  logic [WIDTH-1:0]    in_data2,
  input  logic [WIDTH-1:0]    in_data3,
  output logic [3:0]          in_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_data,
  output logic [CH_IDX_W-1:0] out_sel
);

  if (NCH != tdm_pkg::NCH) begin : g_bad_nch
    $error("tdm_mux_4to1: NCH must be 4");
  end

  state_t              r_state;
  logic [CH_IDX_W-1:0] r_ptr;
  logic [WIDTH-1:0]    r_data;
  logic [CH_IDX_W-1:0] r_sel;

  logic                w_can_load;
  logic [3:0]          w_gnt;
  logic [CH_IDX_W-1:0] w_gidx;
  logic                w_accept;
  logic [WIDTH-1:0]    w_din [4];

  assign w_din[0] = in_data0;
  assign w_din[1] = in_data1;
  assign w_din[2] = in_data2;
  assign w_din[3] = in_data3;

  // A slot frees up either when empty or when the held word leaves now
  assign w_can_load = (r_state == EMPTY) || out_ready;

  rr_arbiter4 u_arb (
    .req     (in_valid),
    .ptr     (r_ptr),
    .en      (w_can_load),
    .gnt     (w_gnt),
    .gnt_idx (w_gidx)
  );

  assign in_ready = w_gnt;
  assign w_accept = |(in_valid & w_gnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_ptr   <= '0;
      r_data  <= '0;
      r_sel   <= '0;
    end else if (w_accept) begin
      r_state <= FULL;
      r_data  <= w_din[w_gidx];
      r_sel   <= w_gidx;
      r_ptr   <= w_gidx + CH_IDX_W'(1);
    end else if (r_state == FULL && out_ready) begin
      r_state <= EMPTY;
    end
  end

  assign out_valid = (r_state == FULL);
  assign out_data  = r_data;
  assign out_sel   = r_sel;

endmodule
